reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb_pkg.sv | 17 +
 rtl/reg_file_sb_if.sv | 36 +++
 rtl/reg_file_sb_score.sv | 66 ++++++
 rtl/reg_file_sb.sv | 99 +++++++++
 tb/tb_reg_file_sb.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Holds the default geometry, the register address type and the
// per-register busy state encoding.
package reg_file_sb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;
    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

    typedef logic [ADDR_W_DEF-1:0] regAddr_t;

    typedef enum logic {
        BUSY_IDLE = 1'b0,
        BUSY_PEND = 1'b1
    } busyState_e;

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle of the scoreboarded register file: two read ports,
// one writeback port, the issue handshake and the pending count.
// The master side drives addresses and strobes; the slave side is the register file.
interface reg_file_sb_if
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] rdAddrA;
    logic [ADDR_W-1:0] rdAddrB;
    logic [DATA_W-1:0] rdDataA;
    logic [DATA_W-1:0] rdDataB;
    logic              rdBusyA;
    logic              rdBusyB;
    logic              wrEnable;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;
    logic              issueValid;
    logic [ADDR_W-1:0] issueAddr;
    logic              issueReady;
    logic [ADDR_W:0]   pendingCnt;

    modport master (
        output rdAddrA, rdAddrB, wrEnable, wrAddr, wrData, issueValid, issueAddr,
        input  rdDataA, rdDataB, rdBusyA, rdBusyB, issueReady, pendingCnt
    );

    modport slave (
        input  rdAddrA, rdAddrB, wrEnable, wrAddr, wrData, issueValid, issueAddr,
        output rdDataA, rdDataB, rdBusyA, rdBusyB, issueReady, pendingCnt
    );

endinterface

// File: rtl/reg_file_sb_score.sv
// Scoreboard for the register file: one IDLE/PEND state per register,
// the write-after-write issue stall and the count of pending registers.
// Register 0 never becomes pending.
module reg_file_sb_score
    import reg_file_sb_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrEnable_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic              issueValid_i,
    input  logic [ADDR_W-1:0] issueAddr_i,
    output logic              issueReady_o,
    output logic [DEPTH-1:0]  busy_o,
    output logic [ADDR_W:0]   pendingCnt_o
);

    busyState_e      state_q [DEPTH];
    busyState_e      state_d [DEPTH];
    logic [ADDR_W:0] pendingCnt_q;
    logic [ADDR_W:0] pendingCnt_d;
    logic            issueTake;
    logic            wrClear;

    // Flatten the per-register states into a busy vector for the read and accept paths
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            busy_o[i] = (state_q[i] == BUSY_PEND);
        end
    end

    assign issueReady_o = issueValid_i & ~busy_o[issueAddr_i];
    assign issueTake    = issueReady_o & (issueAddr_i != '0);
    assign wrClear      = wrEnable_i & (wrAddr_i != '0) & busy_o[wrAddr_i];

    // Next state: writeback retires a register, then an accepted issue claims one (issue wins on a tie)
    always_comb begin
        state_d = state_q;
        if (wrEnable_i && (wrAddr_i != '0)) begin
            state_d[wrAddr_i] = BUSY_IDLE;
        end
        if (issueTake) begin
            state_d[issueAddr_i] = BUSY_PEND;
        end
        pendingCnt_d = pendingCnt_q + {{ADDR_W{1'b0}}, issueTake} - {{ADDR_W{1'b0}}, wrClear};
    end

    // Busy states and pending count, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= BUSY_IDLE;
            end
            pendingCnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pendingCnt_q <= pendingCnt_d;
        end
    end

    assign pendingCnt_o = pendingCnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Scoreboarded register file: DEPTH x DATA_W bank with two combinational
// read ports, one writeback port and an issue port that stalls on a
// pending destination. Register 0 is hardwired to zero.
// Optional feature macro: REG_FILE_SB_BYPASS_EN forwards a same-cycle
// writeback to a matching read port and clears its busy flag.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int INIT_IDX = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_sb_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] bank_q [DEPTH];
    logic [DATA_W-1:0] bank_d [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              issueReady;
    logic [ADDR_W:0]   pendingCnt;
    logic [DATA_W-1:0] rdDataA;
    logic [DATA_W-1:0] rdDataB;
    logic              rdBusyA;
    logic              rdBusyB;

    reg_file_sb_score #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_score (
        .clk          (clk),
        .rst_n        (rst_n),
        .wrEnable_i   (bus.wrEnable),
        .wrAddr_i     (bus.wrAddr),
        .issueValid_i (bus.issueValid),
        .issueAddr_i  (bus.issueAddr),
        .issueReady_o (issueReady),
        .busy_o       (busy),
        .pendingCnt_o (pendingCnt)
    );

    // Bank next state: writeback to any register except r0
    always_comb begin
        bank_d = bank_q;
        if (bus.wrEnable && (bus.wrAddr != '0)) begin
            bank_d[bus.wrAddr] = bus.wrData;
        end
    end

    // Bank storage; reset loads the index pattern or zeros, r0 always resets to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= (INIT_IDX != 0) ? DATA_W'(i) : '0;
            end
        end else begin
            bank_q <= bank_d;
        end
    end

`ifdef REG_FILE_SB_BYPASS_EN
    logic issueTake;
    logic fwdA;
    logic fwdB;

    assign issueTake = bus.issueValid & issueReady & (bus.issueAddr != '0);
    assign fwdA      = bus.wrEnable & (bus.wrAddr == bus.rdAddrA) & (bus.wrAddr != '0);
    assign fwdB      = bus.wrEnable & (bus.wrAddr == bus.rdAddrB) & (bus.wrAddr != '0);
`endif

    // Read muxes: stored value and busy flag, overridden by a matching writeback when forwarding is built in
    always_comb begin
        rdDataA = bank_q[bus.rdAddrA];
        rdDataB = bank_q[bus.rdAddrB];
        rdBusyA = busy[bus.rdAddrA];
        rdBusyB = busy[bus.rdAddrB];
`ifdef REG_FILE_SB_BYPASS_EN
        if (fwdA) begin
            rdDataA = bus.wrData;
            rdBusyA = issueTake & (bus.issueAddr == bus.rdAddrA);
        end
        if (fwdB) begin
            rdDataB = bus.wrData;
            rdBusyB = issueTake & (bus.issueAddr == bus.rdAddrB);
        end
`endif
    end

    assign bus.rdDataA    = rdDataA;
    assign bus.rdDataB    = rdDataB;
    assign bus.rdBusyA    = rdBusyA;
    assign bus.rdBusyB    = rdBusyB;
    assign bus.issueReady = issueReady;
    assign bus.pendingCnt = pendingCnt;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios followed by
// randomized traffic, all compared against an array-based reference model.
// Follows REG_FILE_SB_BYPASS_EN in the same way as the design.
module tb_reg_file_sb;
    import reg_file_sb_pkg::*;

    localparam int DW    = DATA_W_DEF;
    localparam int DEPTH = DEPTH_DEF;

    logic clk;
    logic rst_n;
    int   errCount   = 0;
    int   checkCount = 0;

    logic [31:0] mBank [DEPTH];
    bit          mBusy [DEPTH];

    logic        curWe;
    regAddr_t    curWa;
    logic [31:0] curWd;
    logic        curIv;
    regAddr_t    curIa;
    regAddr_t    curRa;
    regAddr_t    curRb;

    reg_file_sb_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

    reg_file_sb #(.DATA_W(DW), .DEPTH(DEPTH), .INIT_IDX(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the run never reaches its end
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obsVal, input logic [31:0] expVal);
        checkCount++;
        if (obsVal !== expVal) begin
            errCount++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, obsVal, expVal);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < DEPTH; i++) begin
            mBank[i] = 32'(i);
            mBusy[i] = 1'b0;
        end
    endfunction

    function automatic int pendCount();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(mBusy[i]);
        return n;
    endfunction

    function automatic bit modelAccept();
        return curIv && !mBusy[curIa];
    endfunction

    function automatic logic [31:0] expRead(regAddr_t a);
        if (a == 0) return 32'd0;
`ifdef REG_FILE_SB_BYPASS_EN
        if (curWe && curWa == a) return curWd;
`endif
        return mBank[a];
    endfunction

    function automatic bit expBusy(regAddr_t a);
`ifdef REG_FILE_SB_BYPASS_EN
        if (curWe && curWa == a && a != 0) return modelAccept() && curIa == a;
`endif
        return mBusy[a];
    endfunction

    function automatic int pickAddr();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, DEPTH - 1));
        return int'($urandom_range(0, 7));
    endfunction

    // Drive one cycle of inputs at the falling edge and compare every output with the model
    task automatic applyStimulus(input logic we, input int wa, input logic [31:0] wd,
                                 input logic iv, input int ia, input int ra, input int rb);
        @(negedge clk);
        curWe = we;  curWa = regAddr_t'(wa); curWd = wd;
        curIv = iv;  curIa = regAddr_t'(ia);
        curRa = regAddr_t'(ra); curRb = regAddr_t'(rb);
        bus.wrEnable   = curWe;
        bus.wrAddr     = curWa;
        bus.wrData     = curWd;
        bus.issueValid = curIv;
        bus.issueAddr  = curIa;
        bus.rdAddrA    = curRa;
        bus.rdAddrB    = curRb;
        #1;
        checkOutput("issueReady", 32'(bus.issueReady), 32'(modelAccept()));
        checkOutput("rdDataA", bus.rdDataA, expRead(curRa));
        checkOutput("rdDataB", bus.rdDataB, expRead(curRb));
        checkOutput("rdBusyA", 32'(bus.rdBusyA), 32'(expBusy(curRa)));
        checkOutput("rdBusyB", 32'(bus.rdBusyB), 32'(expBusy(curRb)));
        checkOutput("pendingCnt", 32'(bus.pendingCnt), 32'(pendCount()));
    endtask

    // Advance the model across the rising edge
    task automatic commitModel();
        bit acc;
        @(posedge clk);
        acc = modelAccept() && curIa != 0;
        if (curWe && curWa != 0) begin
            mBank[curWa] = curWd;
            mBusy[curWa] = 1'b0;
        end
        if (acc) mBusy[curIa] = 1'b1;
    endtask

    task automatic driveIdle();
        bus.wrEnable   = 1'b0;
        bus.wrAddr     = '0;
        bus.wrData     = '0;
        bus.issueValid = 1'b0;
        bus.issueAddr  = '0;
        bus.rdAddrA    = '0;
        bus.rdAddrB    = '0;
    endtask

    // Directed scenarios, then randomized traffic
    initial begin
        rst_n = 1'b0;
        driveIdle();
        modelReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        applyStimulus(1'b0, 0, 32'd0, 1'b0, 0, 5, 31);
        checkOutput("rstReadA", bus.rdDataA, 32'd5);
        checkOutput("rstReadB", bus.rdDataB, 32'd31);
        checkOutput("rstBusyA", 32'(bus.rdBusyA), 32'd0);
        checkOutput("rstPend", 32'(bus.pendingCnt), 32'd0);
        commitModel();

        // Write-after-write stall on r7
        applyStimulus(1'b0, 0, 32'd0, 1'b1, 7, 7, 0);
        checkOutput("issueR7First", 32'(bus.issueReady), 32'd1);
        commitModel();
        applyStimulus(1'b0, 0, 32'd0, 1'b1, 7, 7, 0);
        checkOutput("issueR7Stall", 32'(bus.issueReady), 32'd0);
        checkOutput("busyR7", 32'(bus.rdBusyA), 32'd1);
        checkOutput("pendR7", 32'(bus.pendingCnt), 32'd1);
        commitModel();

        // Writeback to r7 while reading it
        applyStimulus(1'b1, 7, 32'hDEAD_BEEF, 1'b0, 0, 7, 7);
`ifdef REG_FILE_SB_BYPASS_EN
        checkOutput("fwdDataR7", bus.rdDataA, 32'hDEAD_BEEF);
        checkOutput("fwdBusyR7", 32'(bus.rdBusyA), 32'd0);
`else
        checkOutput("oldDataR7", bus.rdDataA, 32'd7);
        checkOutput("oldBusyR7", 32'(bus.rdBusyA), 32'd1);
`endif
        commitModel();
        applyStimulus(1'b0, 0, 32'd0, 1'b0, 0, 7, 0);
        checkOutput("newDataR7", bus.rdDataA, 32'hDEAD_BEEF);
        checkOutput("newBusyR7", 32'(bus.rdBusyA), 32'd0);
        commitModel();

        // Same-cycle issue and writeback to r3: data lands, busy ends set
        applyStimulus(1'b1, 3, 32'hA5A5_0003, 1'b1, 3, 3, 0);
        checkOutput("issueR3Ready", 32'(bus.issueReady), 32'd1);
        commitModel();
        applyStimulus(1'b0, 0, 32'd0, 1'b0, 0, 3, 0);
        checkOutput("tieDataR3", bus.rdDataA, 32'hA5A5_0003);
        checkOutput("tieBusyR3", 32'(bus.rdBusyA), 32'd1);
        checkOutput("tiePend", 32'(bus.pendingCnt), 32'd1);
        commitModel();

        // r0 ignores writes and issues
        applyStimulus(1'b1, 0, 32'h0000_1234, 1'b1, 0, 0, 0);
        checkOutput("r0Ready", 32'(bus.issueReady), 32'd1);
        checkOutput("r0DataSame", bus.rdDataA, 32'd0);
        commitModel();
        applyStimulus(1'b0, 0, 32'd0, 1'b0, 0, 0, 0);
        checkOutput("r0DataNext", bus.rdDataA, 32'd0);
        checkOutput("r0Busy", 32'(bus.rdBusyA), 32'd0);
        checkOutput("r0Pend", 32'(bus.pendingCnt), 32'd1);
        commitModel();

        // Issue r1, r2, then drop reset between edges during the r3 attempt
        for (int r = 1; r <= 2; r++) begin
            applyStimulus(1'b0, 0, 32'd0, 1'b1, r, 7, 3);
            commitModel();
        end
        applyStimulus(1'b0, 0, 32'd0, 1'b1, 3, 7, 3);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncPend", 32'(bus.pendingCnt), 32'd0);
        checkOutput("asyncBusyA", 32'(bus.rdBusyA), 32'd0);
        checkOutput("asyncBusyB", 32'(bus.rdBusyB), 32'd0);
        checkOutput("asyncDataR7", bus.rdDataA, 32'd7);
        checkOutput("asyncDataR3", bus.rdDataB, 32'd3);
        checkOutput("asyncReady", 32'(bus.issueReady), 32'd1);
        modelReset();
        bus.wrEnable   = 1'b1;
        bus.wrAddr     = 5'd7;
        bus.wrData     = 32'hFFFF_FFFF;
        bus.issueValid = 1'b1;
        bus.issueAddr  = 5'd9;
        @(posedge clk);
        @(negedge clk);
        driveIdle();
        rst_n = 1'b1;
        applyStimulus(1'b0, 0, 32'd0, 1'b0, 0, 7, 9);
        checkOutput("rstIgnWrite", bus.rdDataA, 32'd7);
        checkOutput("rstIgnIssue", 32'(bus.rdBusyB), 32'd0);
        commitModel();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            applyStimulus(logic'($urandom_range(0, 9) < 6), pickAddr(), 32'($urandom),
                          logic'($urandom_range(0, 1)), pickAddr(), pickAddr(), pickAddr());
            commitModel();
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
